// File: rtl/spi_target_if.sv
// spi_target_if: SPI pin and handler byte bundle for spi_target.
//   spi_sclk, spi_cs_n, spi_mosi : SPI pins from the controller (asynchronous to clk)
//   spi_miso                      : SPI data back to the controller
//   spi_tx_byte                   : next byte to transmit, owned by the instruction handler
//   spi_rx_valid / spi_rx_byte    : one-cycle strobe and last completed received byte
// Modports: master = controller/handler side, slave = spi_target.
interface spi_target_if;
   localparam int unsigned BYTE_W = 8;

   logic              spi_sclk;
   logic              spi_cs_n;
   logic              spi_mosi;
   logic              spi_miso;
   logic [BYTE_W-1:0] spi_tx_byte;
   logic              spi_rx_valid;
   logic [BYTE_W-1:0] spi_rx_byte;

   modport master (
      output spi_sclk, spi_cs_n, spi_mosi, spi_tx_byte,
      input  spi_miso, spi_rx_valid, spi_rx_byte
   );

   modport slave (
      input  spi_sclk, spi_cs_n, spi_mosi, spi_tx_byte,
      output spi_miso, spi_rx_valid, spi_rx_byte
   );
endinterface

// File: rtl/spi_target.sv
// spi_target: byte-level SPI mode-0 target, MSB first, oversampled in the clk domain.
//   clk, rst_n : system clock and synchronous active-low reset
//   bus        : spi_target_if.slave (SPI pins, handler tx byte, rx strobe/byte)
// Received bytes appear as a one-cycle spi_rx_valid with spi_rx_byte; spi_tx_byte is
// captured at chip-select assertion and at every byte-boundary sclk falling edge.
module spi_target #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   spi_target_if.slave bus
);
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_W - 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sclk_hist;
   logic                   r_cs_hist;
   logic                   r_armed;

   logic                   w_sclk;
   logic                   w_cs_n;
   logic                   w_mosi;
   logic                   w_sclk_rise;
   logic                   w_sclk_fall;
   logic                   w_cs_fall;
   logic                   w_cs_rise;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic [CNT_W-1:0]       r_cnt;
   logic [BYTE_W-1:0]      r_tx_sr;
   logic [BYTE_W-2:0]      r_rx_sr;
   logic [BYTE_W-1:0]      r_rx_byte;
   logic                   r_rx_valid;

   logic [CNT_W-1:0]       w_cnt_nxt;
   logic [BYTE_W-1:0]      w_tx_sr_nxt;
   logic [BYTE_W-2:0]      w_rx_sr_nxt;
   logic [BYTE_W-1:0]      w_rx_byte_nxt;
   logic                   w_rx_valid_nxt;
   logic [BYTE_W-1:0]      w_rx_shift;

   // Input synchronizers plus one history flop per edge-detected signal.
   // The cs chain resets low and r_armed clears, so a chip select held low across
   // reset is not taken as a new assertion until cs_n has been seen high again.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '0;
         r_mosi_sync <= '0;
         r_sclk_hist <= 1'b0;
         r_cs_hist   <= 1'b1;
         r_armed     <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
         r_sclk_hist <= w_sclk;
         r_cs_hist   <= w_cs_n;
         if (w_cs_n) begin
            r_armed <= 1'b1;
         end
      end
   end

   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk & ~r_sclk_hist;
   assign w_sclk_fall = ~w_sclk & r_sclk_hist;
   assign w_cs_fall   = ~w_cs_n & r_cs_hist & r_armed;
   assign w_cs_rise   = w_cs_n & ~r_cs_hist;
   assign w_rx_shift  = {r_rx_sr, w_mosi};

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_cs_fall) w_state_nxt = ST_ACTIVE;
         ST_ACTIVE: if (w_cs_rise) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath/output next values; cs_rise takes priority over a coincident sclk edge.
   always_comb begin
      w_cnt_nxt      = r_cnt;
      w_tx_sr_nxt    = r_tx_sr;
      w_rx_sr_nxt    = r_rx_sr;
      w_rx_byte_nxt  = r_rx_byte;
      w_rx_valid_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cs_fall) begin
               w_cnt_nxt   = '0;
               w_tx_sr_nxt = bus.spi_tx_byte;
            end
         end
         ST_ACTIVE: begin
            if (w_cs_rise) begin
               // Partial byte discarded; clearing the tx register parks MISO low.
               w_cnt_nxt   = '0;
               w_tx_sr_nxt = '0;
            end else if (w_sclk_rise) begin
               w_rx_sr_nxt = w_rx_shift[BYTE_W-2:0];
               w_cnt_nxt   = r_cnt + CNT_W'(1);
               if (r_cnt == CNT_LAST) begin
                  w_rx_byte_nxt  = w_rx_shift;
                  w_rx_valid_nxt = 1'b1;
               end
            end else if (w_sclk_fall) begin
               if (r_cnt == '0) begin
                  w_tx_sr_nxt = bus.spi_tx_byte;
               end else begin
                  w_tx_sr_nxt = {r_tx_sr[BYTE_W-2:0], 1'b0};
               end
            end
         end
         default: begin
            w_cnt_nxt = '0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_tx_sr    <= '0;
         r_rx_sr    <= '0;
         r_rx_byte  <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_tx_sr    <= w_tx_sr_nxt;
         r_rx_sr    <= w_rx_sr_nxt;
         r_rx_byte  <= w_rx_byte_nxt;
         r_rx_valid <= w_rx_valid_nxt;
      end
   end

   // MISO is the tx register MSB, so it is a direct flop output.
   assign bus.spi_miso     = r_tx_sr[BYTE_W-1];
   assign bus.spi_rx_valid = r_rx_valid;
   assign bus.spi_rx_byte  = r_rx_byte;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: randomized scoreboard bench for spi_target.
// Stimulus drives SPI frames and pushes expected rx bytes / MISO bytes into queues;
// a monitor pops and compares on every spi_rx_valid; a handler model updates
// spi_tx_byte one cycle after each spi_rx_valid.
module tb_spi_target;
   localparam int unsigned SYNC = 2;
   localparam int          HALF = 5;
   localparam int          GAP  = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   spi_target_if bus ();

   spi_target #(.SYNC_STAGES(SYNC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          n_exp    = 0;
   int          n_pulses = 0;
   bit          mon_en   = 1'b0;
   bit          prev_valid = 1'b0;
   bit          h_pending  = 1'b0;
   logic [7:0]  h_nb;
   logic [7:0]  last_rx_exp = 8'h00;
   logic [7:0]  rx_q[$];
   int          lat_q[$];
   logic [7:0]  mq[$];
   logic [7:0]  hnext[$];
   logic [7:0]  tx_preset_q[$];
   logic [7:0]  frame_q[$];

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endfunction

   function automatic void check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
   endfunction

   function automatic void fail_now(input string name, input int act, input int exp);
      n_checks++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every rx_valid pops one expected byte and its launch cycle.
   always @(negedge clk) begin
      if (mon_en && bus.spi_rx_valid) begin
         n_pulses++;
         check("rx_valid single cycle", 32'(prev_valid), 32'h0);
         if (rx_q.size() == 0) begin
            fail_now("unexpected rx_valid pulse", n_pulses, n_exp);
         end else begin
            check("rx_byte", 32'(bus.spi_rx_byte), 32'(rx_q.pop_front()));
            check_range("rx latency", cyc - lat_q.pop_front(), int'(SYNC) + 1, int'(SYNC) + 3);
         end
      end
      prev_valid = bus.spi_rx_valid;
   end

   // Handler model: sole owner of spi_tx_byte.
   always @(negedge clk) begin
      if (tx_preset_q.size() > 0) begin
         bus.spi_tx_byte = tx_preset_q.pop_front();
      end else if (h_pending) begin
         h_nb = (hnext.size() > 0) ? hnext.pop_front() : 8'($urandom);
         bus.spi_tx_byte = h_nb;
         mq.push_back(h_nb);
         h_pending = 1'b0;
      end
      if (mon_en && bus.spi_rx_valid) h_pending = 1'b1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_assert(input logic [7:0] tx0);
      tx_preset_q.push_back(tx0);
      wait_cyc(2);
      mq.delete();
      mq.push_back(tx0);
      bus.spi_cs_n = 1'b0;
      wait_cyc(GAP);
   endtask

   task automatic cs_deassert();
      wait_cyc(HALF);
      bus.spi_cs_n = 1'b1;
      wait_cyc(GAP);
   endtask

   // Clock n bits of b MSB first; acc collects MISO as seen at each raw rising edge.
   task automatic send_bits(input logic [7:0] b, input int n, input bit push, output logic [7:0] acc);
      acc = 8'h00;
      for (int i = 0; i < n; i++) begin
         bus.spi_mosi = b[7-i];
         wait_cyc(HALF);
         bus.spi_sclk = 1'b1;
         acc = {acc[6:0], bus.spi_miso};
         if (push && i == 7) begin
            rx_q.push_back(b);
            lat_q.push_back(cyc);
            last_rx_exp = b;
            n_exp++;
         end
         wait_cyc(HALF);
         bus.spi_sclk = 1'b0;
      end
   endtask

   task automatic run_frame(input logic [7:0] tx0);
      logic [7:0] acc;
      cs_assert(tx0);
      for (int k = 0; k < frame_q.size(); k++) begin
         send_bits(frame_q[k], 8, 1'b1, acc);
         if (mq.size() == 0) fail_now("miso expectation missing", k, 1);
         else check("miso byte", 32'(acc), 32'(mq.pop_front()));
      end
      cs_deassert();
      check("miso low after cs_rise", 32'(bus.spi_miso), 32'h0);
   endtask

   initial begin
      logic [7:0] acc;
      rst_n        = 1'b0;
      bus.spi_sclk = 1'b0;
      bus.spi_cs_n = 1'b1;
      bus.spi_mosi = 1'b0;
      tx_preset_q.push_back(8'h00);
      wait_cyc(4);
      check("reset miso", 32'(bus.spi_miso), 32'h0);
      check("reset rx_valid", 32'(bus.spi_rx_valid), 32'h0);
      check("reset rx_byte", 32'(bus.spi_rx_byte), 32'h0);
      rst_n = 1'b1;
      wait_cyc(GAP);
      mon_en = 1'b1;

      // single byte
      frame_q = '{8'hA5};
      run_frame(8'($urandom));

      // burst
      frame_q = '{8'h01, 8'h00, 8'h00, 8'h2A, 8'hDE};
      run_frame(8'($urandom));

      // transmit 3C then handler-supplied C3
      hnext.push_back(8'hC3);
      frame_q = '{8'($urandom), 8'($urandom)};
      run_frame(8'h3C);

      // aborted partial byte
      cs_assert(8'($urandom));
      send_bits(8'($urandom), 5, 1'b0, acc);
      check("rx_byte held during partial", 32'(bus.spi_rx_byte), 32'(last_rx_exp));
      cs_deassert();
      check("rx_byte held after abort", 32'(bus.spi_rx_byte), 32'(last_rx_exp));
      check("miso low after abort", 32'(bus.spi_miso), 32'h0);
      frame_q = '{8'h7E};
      run_frame(8'($urandom));

      // reset mid-transfer with cs held low
      cs_assert(8'($urandom));
      send_bits(8'($urandom), 3, 1'b0, acc);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("post-reset miso", 32'(bus.spi_miso), 32'h0);
      check("post-reset rx_valid", 32'(bus.spi_rx_valid), 32'h0);
      check("post-reset rx_byte", 32'(bus.spi_rx_byte), 32'h0);
      last_rx_exp = 8'h00;
      tx_preset_q.push_back(8'hFF);
      wait_cyc(1);
      send_bits(8'hFF, 4, 1'b0, acc);
      check("miso idle after reset", 32'(acc[3:0]), 32'h0);
      check("rx_byte after reset bits", 32'(bus.spi_rx_byte), 32'h0);
      cs_deassert();
      frame_q = '{8'h81};
      run_frame(8'($urandom));

      // idle sclk noise
      bus.spi_mosi = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.spi_sclk = ~bus.spi_sclk;
         wait_cyc(HALF);
         check("miso idle noise", 32'(bus.spi_miso), 32'h0);
      end
      wait_cyc(GAP);

      // random frames
      for (int f = 0; f < 6; f++) begin
         frame_q.delete();
         for (int k = 0; k < int'($urandom_range(4, 1)); k++) frame_q.push_back(8'($urandom));
         run_frame(8'($urandom));
      end

      for (int i = 0; i < 20 && rx_q.size() > 0; i++) @(negedge clk);
      check("rx scoreboard drained", 32'(rx_q.size()), 32'h0);
      check("rx pulse count", 32'(n_pulses), 32'(n_exp));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
